// File: rtl/sysid_info_regs.sv
// sysid_info_regs: Avalon-MM slave that identifies the bitstream and gives
// software a few bus sanity-check registers.
//
// Word map: 0 ID, 1 build timestamp, 2 capabilities, 3 scratch (R/W,
// byte-enabled), 4 uptime[31:0], 5 uptime[63:32] snapshot, 6 illegal-write
// count (any write clears it), 7 reads as zero.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   address       word address (3 bits)
//   read          read request, one word per cycle
//   write         write request (wins over a simultaneous read)
//   writedata     write data
//   byteenable    byte lanes for writes
//   readdata      read data, valid when readdatavalid=1, held otherwise
//   readdatavalid one-cycle pulse per accepted read, READ_LATENCY cycles later
module sysid_info_regs #(
    parameter logic [31:0] ID_VALUE      = 32'h00000000,
    parameter logic [31:0] TIMESTAMP     = 32'd1539181635,
    parameter int          READ_LATENCY  = 1,
    parameter int          UPTIME_DIV    = 1,
    parameter logic [31:0] SCRATCH_RESET = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("sysid_info_regs: READ_LATENCY must be in 1..4");
        end
        if (UPTIME_DIV < 1 || UPTIME_DIV > 65535) begin : g_bad_div
            $error("sysid_info_regs: UPTIME_DIV must be in 1..65535");
        end
    endgenerate

    localparam logic [31:0] CAPS_WORD = {8'h02, 8'(READ_LATENCY), 16'(UPTIME_DIV)};
    localparam logic [15:0] PRESC_MAX = 16'(UPTIME_DIV - 1);

    logic [31:0] scratch_q, scratch_d;
    logic [15:0] presc_q,   presc_d;
    logic [63:0] uptime_q,  uptime_d;
    logic [31:0] shadow_q,  shadow_d;
    logic [15:0] bad_wr_q,  bad_wr_d;

    logic [READ_LATENCY-1:0] rd_vld_q;
    logic [31:0]             rd_data_q [READ_LATENCY];

    logic        rd_acc;
    logic        presc_wrap;
    logic [31:0] rdata_mux;

    // A simultaneous write takes the bus; the read is dropped.
    assign rd_acc     = read & ~write;
    assign presc_wrap = (presc_q == PRESC_MAX);

    always_comb begin
        rdata_mux = 32'h0;
        case (address)
            3'd0: rdata_mux = ID_VALUE;
            3'd1: rdata_mux = TIMESTAMP;
            3'd2: rdata_mux = CAPS_WORD;
            3'd3: rdata_mux = scratch_q;
            3'd4: rdata_mux = uptime_q[31:0];
            3'd5: rdata_mux = shadow_q;
            3'd6: rdata_mux = {16'h0, bad_wr_q};
            default: rdata_mux = 32'h0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        if (write && address == 3'd3) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch_d[8*i +: 8] = writedata[8*i +: 8];
                end
            end
        end

        presc_d  = presc_wrap ? 16'h0 : presc_q + 16'd1;
        uptime_d = presc_wrap ? uptime_q + 64'd1 : uptime_q;

        // Reading LO freezes the matching HI half so a later HI read is
        // coherent with the LO value even across a carry.
        shadow_d = (rd_acc && address == 3'd4) ? uptime_q[63:32] : shadow_q;

        bad_wr_d = bad_wr_q;
        if (write) begin
            if (address == 3'd6) begin
                bad_wr_d = 16'h0;
            end else if (address != 3'd3 && bad_wr_q != 16'hFFFF) begin
                bad_wr_d = bad_wr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= SCRATCH_RESET;
            presc_q   <= 16'h0;
            uptime_q  <= 64'h0;
            shadow_q  <= 32'h0;
            bad_wr_q  <= 16'h0;
        end else begin
            scratch_q <= scratch_d;
            presc_q   <= presc_d;
            uptime_q  <= uptime_d;
            shadow_q  <= shadow_d;
            bad_wr_q  <= bad_wr_d;
        end
    end

    // Read pipeline: stage 0 samples the register state of the accepting
    // cycle; data only moves with a valid so the last stage holds readdata.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_data_q[i] <= 32'h0;
            end
        end else begin
            rd_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                rd_data_q[0] <= rdata_mux;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                if (rd_vld_q[i-1]) begin
                    rd_data_q[i] <= rd_data_q[i-1];
                end
            end
        end
    end

    assign readdata      = rd_data_q[READ_LATENCY-1];
    assign readdatavalid = rd_vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed bench for sysid_info_regs with a read scoreboard: each issued read
// pushes its expected word and arrival cycle; a monitor pops on readdatavalid.
module tb_sysid_info_regs;

    localparam logic [31:0] ID  = 32'hCAFE0001;
    localparam logic [31:0] TS  = 32'd1539181635;
    localparam int          RL  = 2;
    localparam int          DIV = 3;
    localparam logic [31:0] SR  = 32'h5A5A0000;
    localparam logic [31:0] CAPS_EXP = {8'h02, 8'(RL), 16'(DIV)};

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    sysid_info_regs #(
        .ID_VALUE     (ID),
        .TIMESTAMP    (TS),
        .READ_LATENCY (RL),
        .UPTIME_DIV   (DIV),
        .SCRATCH_RESET(SR)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .readdata     (readdata),
        .readdatavalid(readdatavalid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
        string       tag;
    } sb_t;

    sb_t sbq[$];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Uptime reference: counts edges since reset release; m_load injects the
    // value the bench forces into the DUT counter.
    logic [63:0] m_up;
    logic [31:0] m_sh;
    int          m_pre;
    logic        m_load = 1'b0;
    logic [63:0] m_load_val = 64'h0;
    logic [63:0] m_base;
    assign m_base = m_load ? m_load_val : m_up;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_up  <= 64'h0;
            m_sh  <= 32'h0;
            m_pre <= 0;
        end else begin
            if (m_pre == DIV - 1) begin
                m_pre <= 0;
                m_up  <= m_base + 64'd1;
            end else begin
                m_pre <= m_pre + 1;
                m_up  <= m_base;
            end
            if (read && !write && address == 3'd4) m_sh <= m_base[63:32];
        end
    end

    int checks = 0, fails = 0;
    int mon_checks = 0, mon_fails = 0;

    initial begin : monitor
        sb_t ent;
        forever begin
            @(negedge clock);
            if (readdatavalid) begin
                if (sbq.size() == 0) begin
                    mon_checks++;
                    mon_fails++;
                    $error("FAIL unexpected_rdv observed readdata=%h required no response", readdata);
                end else begin
                    ent = sbq.pop_front();
                    mon_checks++;
                    assert (readdata === ent.exp) else begin
                        mon_fails++;
                        $error("FAIL %s data observed=%h required=%h", ent.tag, readdata, ent.exp);
                    end
                    mon_checks++;
                    assert (cyc === ent.cyc) else begin
                        mon_fails++;
                        $error("FAIL %s latency observed_cycle=%0d required_cycle=%0d", ent.tag, cyc, ent.cyc);
                    end
                end
            end
        end
    end

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
        sb_t t;
        address = a;
        read    = 1'b1;
        write   = 1'b0;
        t.exp = e;
        t.cyc = cyc + RL;
        t.tag = tag;
        sbq.push_back(t);
        @(negedge clock);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        read       = 1'b0;
        write      = 1'b1;
        writedata  = d;
        byteenable = be;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        read  = 1'b0;
        write = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_no_rdv(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (readdatavalid === 1'b0) else begin
                fails++;
                $error("FAIL %s readdatavalid observed=%b required=0", tag, readdatavalid);
            end
            @(negedge clock);
        end
    endtask

    initial begin : stim
        reset_n    = 1'b0;
        address    = 3'd0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        repeat (3) @(negedge clock);
        checks++;
        assert (readdata === 32'h0) else begin
            fails++;
            $error("FAIL reset_readdata observed=%h required=%h", readdata, 32'h0);
        end
        checks++;
        assert (readdatavalid === 1'b0) else begin
            fails++;
            $error("FAIL reset_rdv observed=%b required=0", readdatavalid);
        end
        reset_n = 1'b1;

        // Uptime after 30 idle cycles with DIV=3: ten increments.
        idle(30);
        checks++;
        assert (m_up[31:0] >= 32'd9 && m_up[31:0] <= 32'd11) else begin
            fails++;
            $error("FAIL uptime_model observed=%0d required=10+-1", m_up[31:0]);
        end
        rd(3'd4, m_up[31:0], "uptime_lo_30");

        // Back-to-back identification reads.
        rd(3'd0, ID, "id");
        rd(3'd1, TS, "timestamp");
        rd(3'd2, CAPS_EXP, "caps");
        idle(4);

        // Scratch byte enables, read right after write, byteenable=0.
        wr(3'd3, 32'h11223344, 4'b1111);
        wr(3'd3, 32'hAABBCCDD, 4'b0101);
        rd(3'd3, 32'h11BB33DD, "scratch_be");
        wr(3'd3, 32'hFFFFFFFF, 4'b0000);
        rd(3'd3, 32'h11BB33DD, "scratch_be0");
        idle(4);

        // Coherent 64-bit read across a carry into bit 32.
        m_load_val = 64'h00000000_FFFFFFFF;
        m_load     = 1'b1;
        force dut.uptime_q = 64'h00000000_FFFFFFFF;
        #1;
        release dut.uptime_q;
        rd(3'd4, 32'hFFFFFFFF, "carry_lo");
        m_load = 1'b0;
        idle(5);
        rd(3'd5, 32'h0, "carry_hi_shadow");
        rd(3'd4, m_up[31:0], "after_carry_lo");
        rd(3'd5, 32'h1, "after_carry_hi");
        idle(4);

        // Illegal-write counter.
        wr(3'd0, 32'h12345678, 4'hF);
        wr(3'd5, 32'h12345678, 4'hF);
        wr(3'd7, 32'h12345678, 4'hF);
        rd(3'd6, 32'd3, "status_3");
        rd(3'd0, ID, "id_unchanged");
        wr(3'd6, 32'h0, 4'hF);
        rd(3'd6, 32'd0, "status_clear");
        idle(1);
        force dut.bad_wr_q = 16'hFFFF;
        #1;
        release dut.bad_wr_q;
        wr(3'd0, 32'h0, 4'hF);
        rd(3'd6, 32'h0000FFFF, "status_sat");
        idle(4);

        // Simultaneous read and write: write wins, read dropped.
        address    = 3'd3;
        read       = 1'b1;
        write      = 1'b1;
        writedata  = 32'hDEADBEEF;
        byteenable = 4'hF;
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
        chk_no_rdv(4, "rw_collision");
        rd(3'd3, 32'hDEADBEEF, "rw_scratch");
        idle(4);

        // Reset with a read in flight.
        address = 3'd3;
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
        reset_n = 1'b0;
        chk_no_rdv(3, "inflight_during_reset");
        reset_n = 1'b1;
        chk_no_rdv(4, "inflight_after_reset");
        rd(3'd3, SR, "scratch_reset");
        idle(6);

        checks++;
        assert (readdata === SR) else begin
            fails++;
            $error("FAIL readdata_hold observed=%h required=%h", readdata, SR);
        end
        checks++;
        assert (sbq.size() === 0) else begin
            fails++;
            $error("FAIL pending_reads observed=%0d required=0", sbq.size());
        end

        $display("%0d/%0d checks passed",
                 (checks + mon_checks) - (fails + mon_fails), checks + mon_checks);
        $finish;
    end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
- Parametrised successor to the single-word system-ID slave. Avalon-MM slave that exposes:
  - the system ID and build timestamp;
  - a capability word;
  - a read/write scratch register;
  - a 64-bit free-running uptime counter with coherent split reads;
  - a counter of illegal writes.
- Reads are pipelined with a configurable fixed latency, signalled by readdatavalid.
- Sits on the control bus beside the CPU so software can identify the bitstream and sanity-check the bus.

Parameters:
- ID_VALUE, 32'h00000000, value returned at word 0.
- TIMESTAMP, 32'd1539181635, value returned at word 1.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal range 1..4.
- UPTIME_DIV, 1, clock cycles per uptime increment; legal range 1..65535.
- SCRATCH_RESET, 32'h00000000, reset value of the scratch register.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- read  in  1  read request, one word per cycle.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  read data, valid when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse per accepted read.

Behaviour:
- Clocking and reset:
  - One clock. reset_n is asynchronous assert, synchronous deassert at the system level.
  - Reset values: readdata=0, readdatavalid=0, all pipeline stages invalid, scratch=SCRATCH_RESET, uptime=0, prescaler=0, shadow_hi=0, bad_wr=0.
- Register map (word addresses):
  - 0 ID: returns ID_VALUE.
  - 1 TIMESTAMP: returns TIMESTAMP.
  - 2 CAPS: returns {8'h02 version, 8'(READ_LATENCY), UPTIME_DIV[15:0]}.
  - 3 SCRATCH: read/write, byte-enabled.
  - 4 UPTIME_LO: returns uptime[31:0]. The same edge latches uptime[63:32] into shadow_hi.
  - 5 UPTIME_HI: returns shadow_hi, not the live counter.
  - 6 STATUS: returns {16'h0, bad_wr[15:0]}. Any write to 6 clears bad_wr to 0.
  - 7: reads as 0.
- Read pipeline:
  - A read is accepted in cycle N when read=1 and write=0. Data is sampled from the register state before the cycle-N edge.
  - readdata/readdatavalid appear after exactly READ_LATENCY edges: readdatavalid=1 in cycle N+READ_LATENCY.
  - Fully pipelined; back-to-back reads on consecutive cycles are returned in order, one per cycle.
  - readdata holds its last value when readdatavalid=0.
- Writes:
  - Take effect at the edge of the write cycle.
  - SCRATCH updates only the lanes where byteenable[i]=1; byteenable=0 has no effect.
  - A read of SCRATCH accepted the cycle after a write returns the new value.
  - Writes to addresses 0,1,2,4,5,7 change nothing except incrementing bad_wr, which saturates at 16'hFFFF.
- Simultaneous read=1 and write=1: the write is performed and the read is dropped (no readdatavalid).
- Uptime:
  - The prescaler counts 0..UPTIME_DIV-1. uptime increments when the prescaler equals UPTIME_DIV-1, then the prescaler returns to 0.
  - UPTIME_DIV=1 means an increment every cycle.
  - uptime wraps from 2^64-1 to 0. It is not writable.
- Coherent 64-bit read: read LO, then HI. HI always corresponds to the LO snapshot, even if a carry into bit 32 occurs between the two reads.
- Reset mid-operation: in-flight reads are discarded, so no readdatavalid occurs after reset deassertion for reads issued before it.
- Illegal parameter values (READ_LATENCY outside 1..4, UPTIME_DIV=0) fail elaboration.

Test Plan:
- Reset, then read addresses 0,1,2 back-to-back, with ID_VALUE=32'hCAFE0001 and READ_LATENCY=2. Required: readdatavalid in cycles N+2, N+3, N+4 with data 32'hCAFE0001, 32'd1539181635, 32'h02020001, in that order.
- Write SCRATCH 32'h11223344 with byteenable=4'b1111, then write 32'hAABBCCDD with byteenable=4'b0101, then read. Required: 32'h11BB33DD.
- UPTIME_DIV=3; hold idle for 30 cycles after reset, then read LO. Required: LO=10 (±1 depending on the sampling edge, checked against a reference model). Force uptime to 64'h00000000_FFFFFFFF, read LO, let it tick, then read HI. Required: LO=32'hFFFFFFFF, HI=0.
- Write to addresses 0, 5, 7. Required: STATUS reads 3 and ID is unchanged. Write to address 6. Required: STATUS reads 0. Force bad_wr to 16'hFFFF and write to address 0. Required: bad_wr remains 16'hFFFF.
- Assert read=1 and write=1 together at address 3. Required: scratch updated, no readdatavalid.
- Issue a read, then assert reset_n=0 one cycle later. Required: readdatavalid=0 throughout and after release, and scratch returns to SCRATCH_RESET.
